tick_timer: RTL and testbench

Programmable down-counting timer that consumes the divided clock produced by the clock-divider stage. Counts rising edges of that divided signal inside the main `clk` domain. Raises a one-cycle `expired` pulse and a sticky `irq` when the programmed count elapses. Runs in one-shot or periodic (auto-reload) mode.

---
 rtl/timer_pkg.sv | 15 +
 rtl/tick_sync.sv | 36 +++
 rtl/tick_timer.sv | 116 +++++++++++
 tb/tb_tick_timer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the tick timer and its tick synchronizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int TIMER_WIDTH_DEFAULT = 16;
    localparam int TIMER_SYNC_MIN      = 2;

endpackage

// File: rtl/tick_sync.sv
// Synchronizes an asynchronous divided clock into clk and emits one pulse per rising edge.
// Latency: rise_pulse is high during the cycle after edge k+SYNC_STAGES-1 (k = first capture edge).
// Backpressure: none; a pulse is produced regardless of the consumer.
//
// Ports: clk, arst_n (async active-low), async_in (raw divided clock),
//        rise_pulse (one clk cycle per async_in rising edge; falling edges ignored).
module tick_sync
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic async_in,
    output logic rise_pulse
);

    // Never build a chain shorter than the metastability minimum.
    localparam int STAGES = (SYNC_STAGES < TIMER_SYNC_MIN) ? TIMER_SYNC_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable down-counter of divided-clock ticks with one-shot/periodic modes, expiry pulse and sticky irq.
// Latency: count updates SYNC_STAGES edges after tick capture; start visible 1 cycle later; expired/irq registered.
// Backpressure: none; strobes act in the cycle they are presented, stop beats start.
//
// Ports: clk, arst_n, tick_in (async divided clock), load_val (terminal count, sampled on start),
//        start/stop (one-cycle strobes), periodic (sampled on start), irq_clr,
//        count (remaining), running (in RUN), expired (one-cycle pulse), irq (sticky).
module tick_timer
    import timer_pkg::*;
#(
    parameter int WIDTH       = TIMER_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             tick_in,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             irq
);

    timer_state_t     state_q, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             mode_q, mode_nxt;
    logic             expired_q, expired_nxt;
    logic             irq_q, irq_nxt;
    logic             tick_pulse;
    logic             start_ok;

    tick_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk        (clk),
        .arst_n     (arst_n),
        .async_in   (tick_in),
        .rise_pulse (tick_pulse)
    );

    // A zero load is treated as if start never arrived; stop always overrides start.
    assign start_ok = start && !stop && (load_val != '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            count_q   <= count_nxt;
            reload_q  <= reload_nxt;
            mode_q    <= mode_nxt;
            expired_q <= expired_nxt;
            irq_q     <= irq_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count_q;
        reload_nxt  = reload_q;
        mode_nxt    = mode_q;
        expired_nxt = 1'b0;
        irq_nxt     = irq_q & ~irq_clr;

        case (state_q)
            RUN: begin
                if (stop) begin
                    // Halt with count frozen; any coincident tick is dropped.
                    state_nxt = IDLE;
                end else if (start_ok) begin
                    count_nxt  = load_val;
                    reload_nxt = load_val;
                    mode_nxt   = periodic;
                end else if (tick_pulse) begin
                    if (count_q == WIDTH'(1)) begin
                        expired_nxt = 1'b1;
                        irq_nxt     = 1'b1;   // expiry beats a coincident irq_clr
                        if (mode_q) begin
                            count_nxt = reload_q;
                        end else begin
                            count_nxt = '0;
                            state_nxt = DONE;
                        end
                    end else begin
                        count_nxt = count_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                // IDLE and DONE: ticks are ignored, only an accepted start matters.
                if (start_ok) begin
                    count_nxt  = load_val;
                    reload_nxt = load_val;
                    mode_nxt   = periodic;
                    state_nxt  = RUN;
                end
            end
        endcase
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign expired = expired_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_tick_timer.sv
module tb_tick_timer;

    typedef enum logic [2:0] {OP_START, OP_STOP, OP_TICK, OP_CLR, OP_SS} op_e;

    typedef struct {
        op_e         op;
        logic [15:0] ld;
        logic        per;
        logic [15:0] e_count;
        logic        e_run;
        logic        e_irq;
        int          e_exp;   // cumulative expired pulses seen so far
    } vec_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic [15:0] load_val = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        periodic = 1'b0;
    logic        irq_clr = 1'b0;
    logic [15:0] count;
    logic        running;
    logic        expired;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int exp_seen = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    tick_timer #(
        .WIDTH       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .tick_in  (tick_in),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .irq_clr  (irq_clr),
        .count    (count),
        .running  (running),
        .expired  (expired),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (expired) exp_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(op_e op, int ld, int per, int ec, int er, int ei, int ee);
        vec_t v;
        v.op = op; v.ld = 16'(ld); v.per = per[0];
        v.e_count = 16'(ec); v.e_run = er[0]; v.e_irq = ei[0]; v.e_exp = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Called #1 after a posedge; returns #1 after a posedge.
    task automatic apply(input vec_t v);
        exp_q.push_back(v);
        load_val = v.ld;
        periodic = v.per;
        case (v.op)
            OP_START: start = 1'b1;
            OP_STOP:  stop = 1'b1;
            OP_CLR:   irq_clr = 1'b1;
            OP_SS:    begin start = 1'b1; stop = 1'b1; end
            default:  tick_in = 1'b1;
        endcase
        if (v.op == OP_TICK) begin
            repeat (3) @(posedge clk);
            #1 tick_in = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
        end
    endtask

    task automatic check_next(input int idx);
        vec_t v;
        v = exp_q.pop_front();
        chk($sformatf("v%0d count", idx), int'(count), int'(v.e_count));
        chk($sformatf("v%0d running", idx), int'(running), int'(v.e_run));
        chk($sformatf("v%0d irq", idx), int'(irq), int'(v.e_irq));
        chk($sformatf("v%0d expired_pulses", idx), exp_seen, v.e_exp);
    endtask

    initial begin
        // One-shot 3
        vecs.push_back(mk(OP_START, 3, 0, 3, 1, 0, 0));
        vecs.push_back(mk(OP_TICK,  0, 0, 2, 1, 0, 0));
        vecs.push_back(mk(OP_TICK,  0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(OP_TICK,  0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(OP_TICK,  0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(OP_CLR,   0, 0, 0, 0, 0, 1));
        // Periodic 2; load_val/periodic driven to 0 during ticks to prove latching
        vecs.push_back(mk(OP_START, 2, 1, 2, 1, 0, 1));
        vecs.push_back(mk(OP_TICK,  0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(OP_TICK,  0, 0, 2, 1, 1, 2));
        vecs.push_back(mk(OP_TICK,  0, 0, 1, 1, 1, 2));
        vecs.push_back(mk(OP_TICK,  0, 0, 2, 1, 1, 3));
        vecs.push_back(mk(OP_TICK,  0, 0, 1, 1, 1, 3));
        vecs.push_back(mk(OP_TICK,  0, 0, 2, 1, 1, 4));
        vecs.push_back(mk(OP_CLR,   0, 0, 2, 1, 0, 4));
        vecs.push_back(mk(OP_STOP,  0, 0, 2, 0, 0, 4));
        vecs.push_back(mk(OP_TICK,  0, 0, 2, 0, 0, 4));
        // Stop / restart
        vecs.push_back(mk(OP_START, 5, 0, 5, 1, 0, 4));
        vecs.push_back(mk(OP_TICK,  0, 0, 4, 1, 0, 4));
        vecs.push_back(mk(OP_TICK,  0, 0, 3, 1, 0, 4));
        vecs.push_back(mk(OP_STOP,  0, 0, 3, 0, 0, 4));
        vecs.push_back(mk(OP_TICK,  0, 0, 3, 0, 0, 4));
        vecs.push_back(mk(OP_START, 4, 0, 4, 1, 0, 4));
        // Collisions and zero load
        vecs.push_back(mk(OP_SS,    7, 0, 4, 0, 0, 4));
        vecs.push_back(mk(OP_START, 0, 0, 4, 0, 0, 4));
        vecs.push_back(mk(OP_START, 1, 0, 1, 1, 0, 4));
        vecs.push_back(mk(OP_TICK,  0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(OP_CLR,   0, 0, 0, 0, 0, 5));
        vecs.push_back(mk(OP_START, 3, 0, 3, 1, 0, 5));
        vecs.push_back(mk(OP_START, 0, 0, 3, 1, 0, 5));
        vecs.push_back(mk(OP_STOP,  0, 0, 3, 0, 0, 5));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", int'(count), 0);
        chk("reset running", int'(running), 0);
        chk("reset expired", int'(expired), 0);
        chk("reset irq", int'(irq), 0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check_next(i);
        end

        // Latency: decrement exactly 2 edges after first capture
        load_val = 16'd5; periodic = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        tick_in = 1'b1;
        @(posedge clk);              // first capture edge
        @(posedge clk); #1;
        chk("lat count_k+1", int'(count), 5);
        @(posedge clk); #1;
        chk("lat count_k+2", int'(count), 4);
        tick_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // One-cycle-wide tick high gives exactly one decrement
        tick_in = 1'b1;
        @(posedge clk); #1 tick_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("narrow count", int'(count), 3);

        // irq_clr coincident with expiry: set wins
        load_val = 16'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("pre_clr irq", int'(irq), 0);
        tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        chk("coll expired", int'(expired), 1);
        chk("coll irq", int'(irq), 1);
        chk("coll count", int'(count), 0);
        chk("coll running", int'(running), 0);
        @(posedge clk); #1;
        chk("coll expired_one_cycle", int'(expired), 0);
        tick_in = 1'b0;
        irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        chk("clr irq", int'(irq), 0);

        // Reset mid-run with a tick pending in the synchronizer
        load_val = 16'd5; periodic = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("prerst count", int'(count), 5);
        tick_in = 1'b1;
        @(posedge clk);
        #3 arst_n = 1'b0;
        #1;
        chk("rst count", int'(count), 0);
        chk("rst running", int'(running), 0);
        chk("rst expired", int'(expired), 0);
        chk("rst irq", int'(irq), 0);
        tick_in = 1'b0;
        @(posedge clk); #1 arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst count", int'(count), 0);
        chk("postrst running", int'(running), 0);
        load_val = 16'd0; periodic = 1'b0;
        tick_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst tick count", int'(count), 0);
        chk("postrst tick running", int'(running), 0);
        load_val = 16'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("postrst start count", int'(count), 2);
        chk("postrst start running", int'(running), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
